// File: rtl/acc_dump.sv
// rtl/acc_dump.sv - accumulate-and-dump stage: sums p_len samples per channel, presents sums on ready/valid
module acc_dump #(
    parameter int p_size  = 12,
    parameter int p_len   = 16,
    parameter int p_grow  = 4,
    parameter int p_cnt_w = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*p_size-1:0]        i_param,
    input  logic [2*p_size-1:0]        i_param_2,
    input  logic                       i_dv,
    input  logic                       i_clr,
    output logic [2*p_size+p_grow-1:0] o_sum,
    output logic [2*p_size+p_grow-1:0] o_sum_2,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_overflow
);

    localparam int sw = 2*p_size + p_grow;
    localparam logic [p_cnt_w-1:0] last_cnt = p_cnt_w'(p_len - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state, state_n;
    logic [sw-1:0]      acc_a, acc_b, acc_a_n, acc_b_n;
    logic [sw-1:0]      sum_a, sum_b;
    logic [sw-1:0]      o_sum_n, o_sum_2_n;
    logic [p_cnt_w-1:0] cnt, cnt_n;
    logic               overflow_n;
    logic               take, dump;

    // Clear wins over a coincident sample; the dump includes the same-cycle sample.
    assign take  = i_dv & ~i_clr;
    assign dump  = take & (cnt == last_cnt);
    assign sum_a = acc_a + sw'(i_param);
    assign sum_b = acc_b + sw'(i_param_2);

    assign o_valid = (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            acc_a      <= '0;
            acc_b      <= '0;
            cnt        <= '0;
            o_sum      <= '0;
            o_sum_2    <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_n;
            acc_a      <= acc_a_n;
            acc_b      <= acc_b_n;
            cnt        <= cnt_n;
            o_sum      <= o_sum_n;
            o_sum_2    <= o_sum_2_n;
            o_overflow <= overflow_n;
        end
    end

    always_comb begin
        state_n    = state;
        acc_a_n    = acc_a;
        acc_b_n    = acc_b;
        cnt_n      = cnt;
        o_sum_n    = o_sum;
        o_sum_2_n  = o_sum_2;
        overflow_n = o_overflow;

        if (i_clr) begin
            acc_a_n    = '0;
            acc_b_n    = '0;
            cnt_n      = '0;
            overflow_n = 1'b0;
        end else if (dump) begin
            acc_a_n = '0;
            acc_b_n = '0;
            cnt_n   = '0;
        end else if (take) begin
            acc_a_n = sum_a;
            acc_b_n = sum_b;
            cnt_n   = cnt + 1'b1;
        end

        case (state)
            FILL: begin
                if (dump) begin
                    o_sum_n   = sum_a;
                    o_sum_2_n = sum_b;
                    state_n   = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    if (dump) begin
                        o_sum_n   = sum_a;
                        o_sum_2_n = sum_b;
                    end else begin
                        state_n = FILL;
                    end
                end else if (dump) begin
                    // Consumer stalled: the fresh result is dropped and the loss is flagged.
                    overflow_n = 1'b1;
                end
            end
            default: state_n = FILL;
        endcase
    end

endmodule
